// File: rtl/unidade_mul_div.sv
// rtl/unidade_mul_div.sv - iterative RV32M multiply/divide unit feeding the register file write port
//
// Purpose: accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation,
// computes it over 32 magnitude iterations, then emits a one-cycle
// register-file write.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous reset, active-high
//   inicio   in   1   start request, sampled only while idle
//   op       in   3   RV32M funct3
//   a        in  32   rs1 operand, captured at start
//   b        in  32   rs2 operand, captured at start
//   rd       in   5   destination register, captured at start
//   ocupado  out  1   unit busy
//   pronto   out  1   one-cycle completion pulse
//   h_esc    out  1   register-file write enable (pronto and resc != 0)
//   resc     out  5   register-file write address
//   dado     out 32   result, held until the next completion or reset

module unidade_mul_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        inicio,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd,
    output logic        ocupado,
    output logic        pronto,
    output logic        h_esc,
    output logic [4:0]  resc,
    output logic [31:0] dado
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINAL  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] a_q, a_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    // Multiply: {partial product high, multiplier bits still to consume}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [63:0] acc_q, acc_d;
    logic        pronto_q, pronto_d;
    logic        h_esc_q, h_esc_d;
    logic [4:0]  resc_q, resc_d;
    logic [31:0] dado_q, dado_d;

    logic        sig_a, sig_b;
    logic        is_div;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] result;

    // Which operands are treated as two's complement for the incoming op.
    always_comb begin
        sig_a = 1'b0;
        sig_b = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sig_a = 1'b1;
                sig_b = 1'b1;
            end
            3'b010:  sig_a = 1'b1;
            default: ;
        endcase
    end

    assign is_div = op_q[2];

    // One shift-add step: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);

    // One restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits.
    assign div_shift = acc_q[63:31];
    assign div_ge    = (div_shift >= {1'b0, mag_b_q});
    assign div_diff  = div_shift[31:0] - mag_b_q;

    // Sign correction and result selection, used in FINAL.
    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_q) : acc_q;
        quo_s  = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_s  = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        result = 32'd0;
        if (!is_div) begin
            result = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
        end else if (mag_b_q == 32'd0) begin
            // Division by zero: quotient all ones, remainder is the raw dividend.
            result = op_q[1] ? a_q : 32'hFFFF_FFFF;
        end else begin
            result = op_q[1] ? rem_s : quo_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        pronto_d = 1'b0;
        h_esc_d  = 1'b0;
        resc_d   = resc_q;
        dado_d   = dado_q;

        case (state_q)
            OCIOSO: begin
                if (inicio) begin
                    op_d    = op;
                    rd_d    = rd;
                    a_d     = a;
                    neg_a_d = sig_a & a[31];
                    neg_b_d = sig_b & b[31];
                    mag_a_d = (sig_a & a[31]) ? (32'd0 - a) : a;
                    mag_b_d = (sig_b & b[31]) ? (32'd0 - b) : b;
                    // Multiply starts from the multiplier, divide from the dividend.
                    acc_d   = op[2] ? {32'd0, ((sig_a & a[31]) ? (32'd0 - a) : a)}
                                    : {32'd0, ((sig_b & b[31]) ? (32'd0 - b) : b)};
                    cnt_d   = 5'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (is_div) begin
                    acc_d = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                dado_d   = result;
                resc_d   = rd_q;
                pronto_d = 1'b1;
                h_esc_d  = (rd_q != 5'd0);
                state_d  = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OCIOSO;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            a_q      <= 32'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= 64'd0;
            pronto_q <= 1'b0;
            h_esc_q  <= 1'b0;
            resc_q   <= 5'd0;
            dado_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            pronto_q <= pronto_d;
            h_esc_q  <= h_esc_d;
            resc_q   <= resc_d;
            dado_q   <= dado_d;
        end
    end

    assign ocupado = (state_q != OCIOSO);
    assign pronto  = pronto_q;
    assign h_esc   = h_esc_q;
    assign resc    = resc_q;
    assign dado    = dado_q;

endmodule

// File: tb/tb_unidade_mul_div.sv
// tb/tb_unidade_mul_div.sv - directed self-checking bench for unidade_mul_div

module tb_unidade_mul_div;

    logic        clk;
    logic        rst;
    logic        inicio;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ocupado;
    logic        pronto;
    logic        h_esc;
    logic [4:0]  resc;
    logic [31:0] dado;

    int checks;
    int errors;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    unidade_mul_div dut (
        .clk     (clk),
        .rst     (rst),
        .inicio  (inicio),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd      (rd),
        .ocupado (ocupado),
        .pronto  (pronto),
        .h_esc   (h_esc),
        .resc    (resc),
        .dado    (dado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an operation, scrambles the inputs after the accepting edge and
    // waits (bounded) for pronto. lat is the number of edges after acceptance
    // at which pronto was first seen; 100 means it never came.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r, output int lat, output int busy,
                          output logic [31:0] d, output logic he, output logic [4:0] rs);
        @(negedge clk);
        op = o; a = x; b = y; rd = r; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0; rd = 5'd31; op = 3'b111;
        busy = ocupado ? 1 : 0;
        lat = 0;
        d = 32'd0; he = 1'b0; rs = 5'd0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (pronto) begin
                d = dado; he = h_esc; rs = resc;
                break;
            end
            if (ocupado) busy++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; inicio = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ocupado, pronto, h_esc} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {ocupado, pronto, h_esc});
        end
        checks++;
        if (resc !== 5'd0 || dado !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got resc=%0d dado=%h expected 0/0", resc, dado);
        end
    endtask

    task automatic test_mul;
        int lat, busy;
        logic [31:0] d;
        logic he;
        logic [4:0] rs;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, busy, d, he, rs);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL mul_latency: got %0d expected 33", lat);
        end
        checks++;
        if (busy !== 33) begin
            errors++;
            $display("FAIL mul_busy_cycles: got %0d expected 33", busy);
        end
        checks++;
        if (d !== 32'hFFFF_FFEB || he !== 1'b1 || rs !== 5'd5) begin
            errors++;
            $display("FAIL mul_write: got dado=%h h_esc=%b resc=%0d expected ffffffeb 1 5", d, he, rs);
        end
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL mul_ocupado_in_pronto: got %b expected 0", ocupado);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pronto !== 1'b0 || h_esc !== 1'b0 || dado !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_pulse_end: got pronto=%b h_esc=%b dado=%h expected 0 0 ffffffeb",
                     pronto, h_esc, dado);
        end
    endtask

    task automatic test_mul_high;
        int lat, busy;
        logic [31:0] d;
        logic he;
        logic [4:0] rs;
        logic [2:0]  v_op [3]  = '{OP_MULH, OP_MULHSU, OP_MULHU};
        logic [31:0] v_a  [3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] v_b  [3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] v_exp[3]  = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 3; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], 5'd9, lat, busy, d, he, rs);
            checks++;
            if (lat !== 33 || d !== v_exp[i]) begin
                errors++;
                $display("FAIL mul_high_%0d: got lat=%0d dado=%h expected 33 %h", i, lat, d, v_exp[i]);
            end
        end
    endtask

    task automatic test_div;
        int lat, busy;
        logic [31:0] d;
        logic he;
        logic [4:0] rs;
        logic [2:0]  v_op [8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU,
                                  OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [31:0] v_a  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] v_b  [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] v_exp[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 8; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], 5'd12, lat, busy, d, he, rs);
            checks++;
            if (lat !== 33 || d !== v_exp[i] || he !== 1'b1 || rs !== 5'd12) begin
                errors++;
                $display("FAIL div_%0d: got lat=%0d dado=%h h_esc=%b resc=%0d expected 33 %h 1 12",
                         i, lat, d, he, rs, v_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd4; rd = 5'd3; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            inicio = (n == 10);
            if (n == 10) begin
                op = OP_DIVU; a = 32'd100; b = 32'd7; rd = 5'd4;
            end
            if (pronto) break;
        end
        inicio = 1'b0;
        checks++;
        if (n !== 33 || dado !== 32'd12 || resc !== 5'd3) begin
            errors++;
            $display("FAIL ignored_start: got n=%0d dado=%h resc=%0d expected 33 0000000c 3", n, dado, resc);
        end
        // Start again during the pronto cycle.
        op = OP_MUL; a = 32'd5; b = 32'd6; rd = 5'd7; inicio = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            inicio = 1'b0;
            n++;
            if (pronto) break;
        end
        checks++;
        if (n !== 34 || dado !== 32'd30 || resc !== 5'd7) begin
            errors++;
            $display("FAIL back_to_back: got n=%0d dado=%h resc=%0d expected 34 0000001e 7", n, dado, resc);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        op = OP_DIV; a = 32'd1000; b = 32'd3; rd = 5'd8; inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ocupado, pronto, h_esc} !== 3'b000 || resc !== 5'd0 || dado !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got ocupado=%b pronto=%b h_esc=%b resc=%0d dado=%h expected all 0",
                     ocupado, pronto, h_esc, resc, dado);
        end
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (pronto || h_esc || ocupado) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_write: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_rd_zero;
        int lat, busy;
        logic [31:0] d;
        logic he;
        logic [4:0] rs;
        run_op(OP_MUL, 32'd2, 32'd3, 5'd0, lat, busy, d, he, rs);
        checks++;
        if (lat !== 33 || he !== 1'b0 || d !== 32'd6 || rs !== 5'd0) begin
            errors++;
            $display("FAIL rd_zero: got lat=%0d h_esc=%b dado=%h resc=%0d expected 33 0 00000006 0",
                     lat, he, d, rs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_back_to_back();
        test_reset_mid();
        test_rd_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
